// File: rtl/axlite2wb_pkg.sv
// axlite2wb_pkg: shared state type and sizing helpers for the axlite2wb bridge.
package axlite2wb_pkg;
    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;
    localparam int WB_BYTE_W = 8;
    function automatic int lanes(input int data_width);
        return data_width / WB_BYTE_W;
    endfunction
endpackage

// File: rtl/axlite2wb_lane_picker.sv
// axlite2wb_lane_picker: lowest set bit of the lane mask as an index and as a one-hot.
module axlite2wb_lane_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_mask,
    output logic [W-1:0] o_idx,
    output logic [N-1:0] o_onehot
);
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) if (i_mask[i]) o_idx = W'(i);
    end
    assign o_onehot = i_mask & (~i_mask + 1'b1);
endmodule

// File: rtl/axlite2wb_byte_serializer.sv
// axlite2wb_byte_serializer: splits one word request into byte-wide Wishbone classic
// cycles, one per enabled lane, and returns a single word response with error status.
module axlite2wb_byte_serializer
    import axlite2wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [7:0]              wb_dat_o,
    input  logic [7:0]              wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);
    localparam int LANES = lanes(DATA_WIDTH);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW    = $clog2(TIMEOUT + 2);
    localparam int PW    = $clog2(LANES + 1);

    function automatic logic [PW-1:0] popcnt(input logic [LANES-1:0] m);
        popcnt = '0;
        for (int i = 0; i < LANES; i++) popcnt = popcnt + PW'(m[i]);
    endfunction

    state_t                r_state;
    logic [LANES-1:0]      r_mask;
    logic                  r_we;
    logic                  r_cyc;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [CW-1:0]         r_cnt;
    logic [PW-1:0]         r_left;

    logic [LW-1:0]    w_idx;
    logic [LANES-1:0] w_bit;
    logic [LANES-1:0] w_mask_in;
    logic             w_last;
    logic             w_abort;

    axlite2wb_lane_picker #(.N(LANES), .W(LW)) u_picker (
        .i_mask  (r_mask),
        .o_idx   (w_idx),
        .o_onehot(w_bit)
    );

    assign w_mask_in = req_we ? req_strb : '1;
    assign w_last    = (r_mask & ~w_bit) == '0;
    // Error always wins; a timeout yields to an ack arriving in the same cycle.
    assign w_abort   = wb_err_i || (!wb_ack_i && TIMEOUT != 0 && int'(r_cnt) + 1 == TIMEOUT);

    assign req_ready = rst_n && r_state == IDLE;
    assign rsp_valid = r_state == RESP;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_cyc & r_we;
    assign wb_adr_o  = (r_addr & ~ADDR_WIDTH'(LANES - 1)) | ADDR_WIDTH'(w_idx);
    assign wb_dat_o  = r_wdata[w_idx*WB_BYTE_W +: WB_BYTE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_left  <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                    r_mask  <= w_mask_in;
                    r_left  <= popcnt(w_mask_in);
                    r_cyc   <= |w_mask_in;
                    r_state <= |w_mask_in ? BEAT : RESP;
                end
                BEAT: if (w_abort) begin
                    r_err   <= 1'b1;
                    r_mask  <= '0;
                    r_cyc   <= 1'b0;
                    r_state <= RESP;
                end else if (wb_ack_i) begin
                    r_mask <= r_mask & ~w_bit;
                    r_cnt  <= '0;
                    r_left <= r_left - 1'b1;
                    if (!r_we) r_rdata[w_idx*WB_BYTE_W +: WB_BYTE_W] <= wb_dat_i;
                    if (w_last) begin
                        r_cyc   <= 1'b0;
                        r_state <= RESP;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                RESP: if (rsp_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // The final ack of a clean burst must consume exactly the popcount of the lane mask.
    assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == BEAT && wb_ack_i && !wb_err_i && w_last) |-> r_left == PW'(1));
endmodule

// File: tb/tb_axlite2wb_byte_serializer.sv
// tb_axlite2wb_byte_serializer: directed checks of burst splitting, reads, errors,
// timeout, response stall and asynchronous reset.
module tb_axlite2wb_byte_serializer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]  wb_adr_o, wb_dat_o;
    logic [7:0]  wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    axlite2wb_byte_serializer #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents a request for one edge; returns at the negedge of the first cycle after accept.
    task automatic issue(input logic we, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        req_we = we; req_addr = a; req_wdata = d; req_strb = s; req_valid = 1'b1;
        chk("accept_ready", {31'b0, req_ready}, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_done_valid", {31'b0, rsp_valid}, 0);
        chk("rsp_done_ready", {31'b0, req_ready}, 1);
    endtask

    initial begin
        #1;
        chk("rst_ready_low", {31'b0, req_ready}, 0);
        chk("rst_cyc", {31'b0, wb_cyc_o}, 0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("rel_ready", {31'b0, req_ready}, 1);
        chk("rel_stb", {31'b0, wb_stb_o}, 0);
        chk("rel_we", {31'b0, wb_we_o}, 0);
        chk("rel_adr", {24'b0, wb_adr_o}, 0);
        chk("rel_dat", {24'b0, wb_dat_o}, 0);
        chk("rel_rdata", rsp_rdata, 0);
        chk("rel_err", {31'b0, rsp_err}, 0);
        tick();

        // Sparse write: lanes 1 and 3 only
        issue(1'b1, 8'h10, 32'hA1B2C3D4, 4'b1010);
        chk("w1_cyc", {31'b0, wb_cyc_o}, 1);
        chk("w1_stb", {31'b0, wb_stb_o}, 1);
        chk("w1_we", {31'b0, wb_we_o}, 1);
        chk("w1_adr0", {24'b0, wb_adr_o}, 32'h11);
        chk("w1_dat0", {24'b0, wb_dat_o}, 32'hC3);
        chk("w1_busy", {31'b0, req_ready}, 0);
        wb_ack_i = 1'b1;
        tick();
        chk("w1_cyc1", {31'b0, wb_cyc_o}, 1);
        chk("w1_adr1", {24'b0, wb_adr_o}, 32'h13);
        chk("w1_dat1", {24'b0, wb_dat_o}, 32'hA1);
        chk("w1_novalid", {31'b0, rsp_valid}, 0);
        tick();
        wb_ack_i = 1'b0;
        chk("w1_cyc_off", {31'b0, wb_cyc_o}, 0);
        chk("w1_stb_off", {31'b0, wb_stb_o}, 0);
        chk("w1_rsp_valid", {31'b0, rsp_valid}, 1);
        chk("w1_rsp_err", {31'b0, rsp_err}, 0);
        chk("w1_rdata", rsp_rdata, 0);
        finish_rsp();

        // Full read with one wait state per beat
        issue(1'b0, 8'h04, 32'h0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            chk("r2_adr", {24'b0, wb_adr_o}, 32'h04 + i);
            chk("r2_we", {31'b0, wb_we_o}, 0);
            wb_ack_i = 1'b0;
            tick();
            chk("r2_adr_wait", {24'b0, wb_adr_o}, 32'h04 + i);
            chk("r2_cyc_wait", {31'b0, wb_cyc_o}, 1);
            wb_ack_i = 1'b1;
            wb_dat_i = 8'h11 * 8'(i + 1);
            tick();
        end
        wb_ack_i = 1'b0;
        chk("r2_rsp_valid", {31'b0, rsp_valid}, 1);
        chk("r2_rdata", rsp_rdata, 32'h44332211);
        chk("r2_err", {31'b0, rsp_err}, 0);
        chk("r2_cyc_off", {31'b0, wb_cyc_o}, 0);
        finish_rsp();

        // Zero-strobe write: immediate response, no bus cycle
        issue(1'b1, 8'h50, 32'hDEADBEEF, 4'b0000);
        chk("z3_cyc", {31'b0, wb_cyc_o}, 0);
        chk("z3_rsp_valid", {31'b0, rsp_valid}, 1);
        chk("z3_err", {31'b0, rsp_err}, 0);
        finish_rsp();
        chk("z3_cyc_after", {31'b0, wb_cyc_o}, 0);

        // Error on second beat aborts remaining lanes
        issue(1'b1, 8'h20, 32'h55667788, 4'b1111);
        chk("e4_adr0", {24'b0, wb_adr_o}, 32'h20);
        chk("e4_dat0", {24'b0, wb_dat_o}, 32'h88);
        wb_ack_i = 1'b1;
        tick();
        chk("e4_adr1", {24'b0, wb_adr_o}, 32'h21);
        chk("e4_dat1", {24'b0, wb_dat_o}, 32'h77);
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        chk("e4_cyc_off", {31'b0, wb_cyc_o}, 0);
        chk("e4_stb_off", {31'b0, wb_stb_o}, 0);
        chk("e4_rsp_valid", {31'b0, rsp_valid}, 1);
        chk("e4_err", {31'b0, rsp_err}, 1);
        finish_rsp();
        tick();
        chk("e4_no_more", {31'b0, wb_cyc_o}, 0);

        // Silent slave: timeout after 4 stb cycles, then stalled response
        issue(1'b0, 8'h30, 32'h0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            chk("t5_stb", {31'b0, wb_stb_o}, 1);
            tick();
        end
        chk("t5_stb_off", {31'b0, wb_stb_o}, 0);
        chk("t5_rsp_valid", {31'b0, rsp_valid}, 1);
        chk("t5_err", {31'b0, rsp_err}, 1);
        req_we = 1'b1; req_addr = 8'h60; req_strb = 4'b0001; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", {31'b0, rsp_valid}, 1);
            chk("t5_hold_err", {31'b0, rsp_err}, 1);
            chk("t5_hold_rdata", rsp_rdata, 0);
            chk("t5_hold_ready", {31'b0, req_ready}, 0);
            chk("t5_hold_cyc", {31'b0, wb_cyc_o}, 0);
        end
        req_valid = 1'b0;
        finish_rsp();
        chk("t5_idle_cyc", {31'b0, wb_cyc_o}, 0);

        // Asynchronous reset during a beat
        issue(1'b1, 8'h40, 32'h000000EE, 4'b0001);
        chk("r6_cyc_on", {31'b0, wb_cyc_o}, 1);
        rst_n = 1'b0;
        #1;
        chk("r6_cyc_clr", {31'b0, wb_cyc_o}, 0);
        chk("r6_stb_clr", {31'b0, wb_stb_o}, 0);
        chk("r6_rsp_clr", {31'b0, rsp_valid}, 0);
        chk("r6_ready_low", {31'b0, req_ready}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("r6_ready_rel", {31'b0, req_ready}, 1);
        tick();
        chk("r6_no_rsp", {31'b0, rsp_valid}, 0);
        chk("r6_no_cyc", {31'b0, wb_cyc_o}, 0);
        issue(1'b0, 8'h08, 32'h0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            chk("r6_adr", {24'b0, wb_adr_o}, 32'h08 + i);
            chk("r6_novalid", {31'b0, rsp_valid}, 0);
            wb_ack_i = 1'b1;
            wb_dat_i = 8'hAA + 8'(i * 8'h11);
            tick();
        end
        wb_ack_i = 1'b0;
        chk("r6_rsp_valid", {31'b0, rsp_valid}, 1);
        chk("r6_rdata", rsp_rdata, 32'hDDCCBBAA);
        chk("r6_err", {31'b0, rsp_err}, 0);
        finish_rsp();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
